// File: rtl/if_stage_pkg.sv
// Shared types for the instruction-fetch stage: the IF->ID payload and the ID->IF branch record.
package if_stage_pkg;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // Packed so instr lands in [63:32] and pc in [31:0].
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fs_data_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } branch_data_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundles the fetch stage's instruction-memory port, the IF->ID handshake and the branch record.
interface if_stage_if;
  import if_stage_pkg::*;

  logic         inst_req_valid;
  logic         inst_req_ready;
  logic [31:0]  inst_req_addr;
  logic         inst_resp_valid;
  logic [31:0]  inst_resp_data;
  logic         ds_allowin;
  logic         fs_to_ds_valid;
  fs_data_t     fs_data;
  branch_data_t branch_data;

  modport master (
    output inst_req_valid, inst_req_addr, fs_to_ds_valid, fs_data,
    input  inst_req_ready, inst_resp_valid, inst_resp_data, ds_allowin, branch_data
  );

  modport slave (
    input  inst_req_valid, inst_req_addr, fs_to_ds_valid, fs_data,
    output inst_req_ready, inst_resp_valid, inst_resp_data, ds_allowin, branch_data
  );

endinterface

// File: rtl/fs_fifo.sv
// Synchronous FIFO with flush and occupancy count; flush takes priority over push and pop.
module fs_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, credit-limited fetch requests, response tagging and redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic        clk,
  input logic        rst_n,
  if_stage_if.master bus
);

  localparam int unsigned InFlightW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned OutCntW   = $clog2(FIFO_DEPTH + 1);

  logic [31:0]          pc_q, pc_d;
  logic [InFlightW-1:0] in_flight_q, in_flight_d;
  logic [InFlightW-1:0] discard_q, discard_d;
  logic                 active_q;

  logic                 taken, credit, fire, resp_ok, out_push, out_pop;
  logic [31:0]          tag_head;
  logic [InFlightW-1:0] tag_count;
  logic                 tag_empty, tag_full;
  logic [63:0]          out_head;
  logic [OutCntW-1:0]   out_count;
  logic                 out_empty, out_full;
  fs_data_t             out_push_data;
  logic                 unused_tag;

  assign taken = bus.branch_data.taken;

  // Counting in-flight requests against free buffer slots guarantees every response a home.
  assign credit = active_q && !tag_full
               && (32'(in_flight_q) + 32'(out_count) < FIFO_DEPTH)
               && (32'(in_flight_q) < MAX_OUTSTANDING);

  assign bus.inst_req_valid = credit && !taken;
  assign bus.inst_req_addr  = pc_q;
  assign fire               = bus.inst_req_valid && bus.inst_req_ready;
  assign resp_ok            = bus.inst_resp_valid && (in_flight_q != '0);
  assign out_push           = resp_ok && (discard_q == '0) && !taken && !out_full;
  assign out_pop            = !out_empty && bus.ds_allowin;
  assign out_push_data      = '{instr: bus.inst_resp_data, pc: tag_head};
  assign bus.fs_to_ds_valid = !out_empty;
  assign bus.fs_data        = out_empty ? '0 : fs_data_t'(out_head);
  assign unused_tag         = ^{tag_count, tag_empty};

  always_comb begin
    pc_d = pc_q;
    if (taken) begin
      pc_d = word_align(bus.branch_data.target);
    end else if (fire) begin
      pc_d = pc_q + INSTR_BYTES;
    end

    in_flight_d = in_flight_q + InFlightW'(fire) - InFlightW'(resp_ok);

    discard_d = discard_q;
    if (resp_ok && (discard_q != '0)) begin
      discard_d = discard_q - InFlightW'(1);
    end
    // Everything still outstanding after a redirect belongs to the old path.
    if (taken) begin
      discard_d = in_flight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      in_flight_q <= '0;
      discard_q   <= '0;
      active_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      in_flight_q <= in_flight_d;
      discard_q   <= discard_d;
      active_q    <= 1'b1;
    end
  end

  fs_fifo #(
    .WIDTH(32),
    .DEPTH(MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (1'b0),
    .push     (fire),
    .push_data(pc_q),
    .pop      (resp_ok),
    .head     (tag_head),
    .count    (tag_count),
    .empty    (tag_empty),
    .full     (tag_full)
  );

  fs_fifo #(
    .WIDTH($bits(fs_data_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (taken),
    .push     (out_push),
    .push_data(out_push_data),
    .pop      (out_pop),
    .head     (out_head),
    .count    (out_count),
    .empty    (out_empty),
    .full     (out_full)
  );

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a 1-cycle-latency memory model and an ID-side monitor.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic clk;
  logic rst_n;
  logic hold;
  int   n_cmp = 0;
  int   n_err = 0;
  int   consumed = 0;
  int   fires = 0;
  logic [31:0] first_addr;
  logic [31:0] pend[$];
  fs_data_t    exp_q[$];

  if_stage_if bus ();

  if_stage #(
    .RESET_PC       (RESET_PC),
    .FIFO_DEPTH     (2),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[13:2], 20'h00013};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic expect_stream(input logic [31:0] start);
    logic [31:0] pc;
    pc = start;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back('{instr: instr_of(pc), pc: pc});
      pc += 32'd4;
    end
  endtask

  task automatic wait_consumed(input int n, input string name);
    int start;
    start = consumed;
    for (int i = 0; i < 40 && consumed < start + n; i++) @(posedge clk);
    check(name, 64'((consumed >= start + n) ? n : consumed - start), 64'(n));
  endtask

  task automatic wait_first_fire(input string name);
    for (int i = 0; i < 20 && fires == 0; i++) @(posedge clk);
    check(name, (fires > 0) ? 64'(first_addr) : 64'hdead, 64'(RESET_PC));
  endtask

  // Memory: sample fires late in the cycle, answer in the cycle after the fire edge.
  initial begin
    bus.inst_resp_valid = 1'b0;
    bus.inst_resp_data  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        pend.delete();
      end else if (bus.inst_req_valid && bus.inst_req_ready) begin
        if (fires == 0) first_addr = bus.inst_req_addr;
        fires++;
        pend.push_back(bus.inst_req_addr);
      end
      @(posedge clk);
      #1;
      if (rst_n && !hold && pend.size() > 0) begin
        bus.inst_resp_valid = 1'b1;
        bus.inst_resp_data  = instr_of(pend.pop_front());
      end else begin
        bus.inst_resp_valid = 1'b0;
        bus.inst_resp_data  = '0;
      end
    end
  end

  // ID-side monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.fs_to_ds_valid && bus.ds_allowin) begin
        consumed++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL fs_data: got %h with no expected entry", bus.fs_data);
        end else begin
          check("fs_data", bus.fs_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    rst_n              = 1'b0;
    hold               = 1'b0;
    bus.inst_req_ready = 1'b0;
    bus.ds_allowin     = 1'b0;
    bus.branch_data    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_valid", 64'(bus.inst_req_valid), 64'd0);
    check("reset_fs_valid", 64'(bus.fs_to_ds_valid), 64'd0);
    check("reset_fs_data", bus.fs_data, 64'd0);

    // 1: sequential fetch from RESET_PC
    expect_stream(RESET_PC);
    fires = 0;
    @(posedge clk); #1;
    rst_n = 1'b1; bus.inst_req_ready = 1'b1; bus.ds_allowin = 1'b1;
    wait_first_fire("t1_first_addr");
    wait_consumed(3, "t1_stream");

    // 2: back-pressure from ID from an idle pipe
    @(posedge clk); #1;
    bus.inst_req_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    bus.ds_allowin = 1'b0; bus.inst_req_ready = 1'b1; fires = 0;
    repeat (10) @(negedge clk);
    check("t2_fires", 64'(fires), 64'd2);
    check("t2_req_valid", 64'(bus.inst_req_valid), 64'd0);
    @(posedge clk); #1;
    bus.ds_allowin = 1'b1;
    wait_consumed(4, "t2_resume");

    // 3: redirect with two requests in flight
    @(posedge clk); #1;
    bus.inst_req_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    hold = 1'b1; bus.inst_req_ready = 1'b1; fires = 0;
    repeat (4) @(posedge clk);
    #1;
    check("t3_inflight", 64'(fires), 64'd2);
    check("t3_req_valid", 64'(bus.inst_req_valid), 64'd0);
    bus.branch_data = '{taken: 1'b1, target: 32'h8000_0100};
    @(posedge clk); #1;
    bus.branch_data = '0; hold = 1'b0;
    expect_stream(32'h8000_0100);
    wait_consumed(3, "t3_target");

    // 5: request held under a memory stall, then redirected mid-stall
    @(posedge clk); #1;
    bus.inst_req_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    bus.branch_data = '{taken: 1'b1, target: 32'h8000_0200};
    @(posedge clk); #1;
    bus.branch_data = '0;
    expect_stream(32'h8000_0200);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_stall", 64'({bus.inst_req_valid, bus.inst_req_addr}), {31'd0, 1'b1, 32'h8000_0200});
    end
    @(posedge clk); #1;
    bus.branch_data = '{taken: 1'b1, target: 32'h8000_0302};
    @(posedge clk); #1;
    bus.branch_data = '0;
    expect_stream(32'h8000_0300);
    @(negedge clk);
    check("t5_redirect", 64'({bus.inst_req_valid, bus.inst_req_addr}), {31'd0, 1'b1, 32'h8000_0300});
    @(posedge clk); #1;
    bus.inst_req_ready = 1'b1;
    wait_consumed(3, "t5_resume");

    // 4: redirect coinciding with a response and an ID pop; target crosses the 32-bit wrap
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.fs_to_ds_valid && bus.inst_resp_valid && bus.ds_allowin) begin
        found = 1'b1;
        bus.branch_data = '{taken: 1'b1, target: 32'hFFFF_FFF8};
      end
    end
    check("t4_trigger", 64'(found), 64'd1);
    if (found) begin
      @(posedge clk); #1;
      bus.branch_data = '0;
      expect_stream(32'hFFFF_FFF8);
      @(negedge clk);
      check("t4_flush", 64'(bus.fs_to_ds_valid), 64'd0);
      wait_consumed(4, "t4_wrap");
    end

    // 6: reset with a full output buffer
    @(posedge clk); #1;
    bus.ds_allowin = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_req_valid", 64'(bus.inst_req_valid), 64'd0);
    check("t6_fs_valid", 64'(bus.fs_to_ds_valid), 64'd0);
    check("t6_fs_data", bus.fs_data, 64'd0);
    @(posedge clk); #1;
    fires = 0;
    expect_stream(RESET_PC);
    bus.ds_allowin = 1'b1;
    rst_n = 1'b1;
    wait_first_fire("t6_first_addr");
    wait_consumed(3, "t6_stream");

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
